// File: rtl/rr_shared_reg_arbiter.sv
// rr_shared_reg_arbiter: round-robin owner of one shared DFF register.
// Grants one requester per 3-cycle transaction, then rotates priority.
module rr_shared_reg_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 8
) (
    input  logic                        clk,
    input  logic                        reset_in,
    input  logic [NUM_REQ-1:0]          req_in,
    input  logic [NUM_REQ*DATA_W-1:0]   data_in,
    output logic [NUM_REQ-1:0]          grant_out,
    output logic [NUM_REQ-1:0]          ack_out,
    output logic [DATA_W-1:0]           reg_q_out,
    output logic [CNT_W-1:0]            wr_count_out,
    output logic                        busy_out
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t              state_q;
    logic [PW-1:0]       ptr_q;
    logic [PW-1:0]       ptr_d;
    logic [PW-1:0]       win_q;
    logic [PW-1:0]       win_d;
    logic                hit_d;
    logic [NUM_REQ-1:0]  grant_q;
    logic [NUM_REQ-1:0]  ack_q;
    logic [DATA_W-1:0]   reg_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                busy_q;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [PW-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Winner search: first raised request starting at ptr, wrapping.
    always_comb begin
        int            s;
        logic [PW-1:0] cand;
        hit_d = 1'b0;
        win_d = '0;
        s     = 0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            s = int'(ptr_q) + k;
            if (s >= NUM_REQ) begin
                s = s - NUM_REQ;
            end
            cand = PW'(s);
            if (!hit_d && req_in[cand]) begin
                hit_d = 1'b1;
                win_d = cand;
            end
        end
    end

    // Priority moves to the requester just after the one served.
    always_comb begin
        ptr_d = (win_q == PW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
    end

    // Transaction FSM; every output is a register.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            reg_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (hit_d) begin
                        win_q   <= win_d;
                        grant_q <= onehot(win_d);
                        busy_q  <= 1'b1;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (req_in[win_q]) begin
                        reg_q   <= data_in[int'(win_q)*DATA_W +: DATA_W];
                        ack_q   <= onehot(win_q);
                        cnt_q   <= cnt_q + 1'b1;
                        state_q <= ACK;
                    end else begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                ACK: begin
                    ack_q   <= '0;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    ptr_q   <= ptr_d;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant_out    = grant_q;
    assign ack_out      = ack_q;
    assign reg_q_out    = reg_q;
    assign wr_count_out = cnt_q;
    assign busy_out     = busy_q;

endmodule

// File: tb/tb_rr_shared_reg_arbiter.sv
// tb_rr_shared_reg_arbiter: directed reset/abort cases, then random
// requesters checked by a transaction-level model through a scoreboard.
module tb_rr_shared_reg_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CW = 8;
    localparam int NCYC = 3000;

    logic            clk;
    logic            reset_in;
    logic [N-1:0]    req_in;
    logic [N*DW-1:0] data_in;
    logic [N-1:0]    grant_out;
    logic [N-1:0]    ack_out;
    logic [DW-1:0]   reg_q_out;
    logic [CW-1:0]   wr_count_out;
    logic            busy_out;

    rr_shared_reg_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (DW),
        .CNT_W   (CW)
    ) dut (
        .clk          (clk),
        .reset_in     (reset_in),
        .req_in       (req_in),
        .data_in      (data_in),
        .grant_out    (grant_out),
        .ack_out      (ack_out),
        .reg_q_out    (reg_q_out),
        .wr_count_out (wr_count_out),
        .busy_out     (busy_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          w;
        logic [7:0]  d;
        logic [7:0]  c;
    } exp_t;

    int   gq[$];
    exp_t aq[$];
    int   vec = 0;
    int   errs = 0;
    bit   mon_en = 1'b0;
    logic [N-1:0] prev_grant = '0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever a grant starts or an ack shows.
    always @(negedge clk) begin
        if (mon_en && !reset_in) begin
            chk("busy_vs_grant", {31'd0, busy_out}, {31'd0, grant_out != 0});
            chk("onehot_grant", {31'd0, $onehot0(grant_out)}, 32'd1);
            chk("onehot_ack", {31'd0, $onehot0(ack_out)}, 32'd1);
            if (grant_out != 0 && prev_grant == 0) begin
                if (gq.size() == 0) begin
                    chk("unexpected_grant", {28'd0, grant_out}, 32'd0);
                end else begin
                    int w;
                    w = gq.pop_front();
                    chk("grant", {28'd0, grant_out}, 32'd1 << w);
                end
            end
            if (ack_out != 0) begin
                if (aq.size() == 0) begin
                    chk("unexpected_ack", {28'd0, ack_out}, 32'd0);
                end else begin
                    exp_t e;
                    e = aq.pop_front();
                    chk("ack", {28'd0, ack_out}, 32'd1 << e.w);
                    chk("ack_grant", {28'd0, grant_out}, 32'd1 << e.w);
                    chk("reg_q", {24'd0, reg_q_out}, {24'd0, e.d});
                    chk("wr_count", {24'd0, wr_count_out}, {24'd0, e.c});
                end
            end
            prev_grant = grant_out;
        end
    end

    task automatic chk_idle(input string nm, input logic [7:0] rq,
                            input logic [7:0] cnt);
        chk({nm, "_grant"}, {28'd0, grant_out}, 32'd0);
        chk({nm, "_ack"}, {28'd0, ack_out}, 32'd0);
        chk({nm, "_busy"}, {31'd0, busy_out}, 32'd0);
        chk({nm, "_reg"}, {24'd0, reg_q_out}, {24'd0, rq});
        chk({nm, "_cnt"}, {24'd0, wr_count_out}, {24'd0, cnt});
    endtask

    // Reference model state for the random phase.
    int         free_at;
    int         ptr;
    int         win;
    int         samp_at;
    int         drop_at [N];
    logic [7:0] dat [N];
    logic [7:0] mcnt;

    initial begin
        reset_in = 1'b1;
        req_in   = '0;
        data_in  = '0;
        repeat (2) @(negedge clk);
        chk_idle("reset", 8'h00, 8'h00);
        reset_in = 1'b0;

        // Single write from requester 1.
        req_in = 4'b0010;
        data_in[1*DW +: DW] = 8'hA5;
        @(negedge clk);
        chk("single_grant", {28'd0, grant_out}, 32'h2);
        chk("single_busy", {31'd0, busy_out}, 32'd1);
        chk("single_noack", {28'd0, ack_out}, 32'd0);
        @(negedge clk);
        chk("single_ack", {28'd0, ack_out}, 32'h2);
        chk("single_reg", {24'd0, reg_q_out}, 32'hA5);
        chk("single_cnt", {24'd0, wr_count_out}, 32'd1);
        req_in = '0;
        @(negedge clk);
        chk_idle("single_done", 8'hA5, 8'd1);

        // Requester 2 write, reset asserted while its ack is showing.
        req_in = 4'b0100;
        data_in[2*DW +: DW] = 8'h5A;
        @(negedge clk);
        chk("r2_grant", {28'd0, grant_out}, 32'h4);
        @(negedge clk);
        chk("r2_ack", {28'd0, ack_out}, 32'h4);
        reset_in = 1'b1;
        req_in   = '0;
        #1;
        chk_idle("async_reset", 8'h00, 8'h00);
        @(negedge clk);
        reset_in = 1'b0;

        // Pointer back at 0: 0110 must go to requester 1.
        req_in = 4'b0110;
        data_in[1*DW +: DW] = 8'h11;
        data_in[2*DW +: DW] = 8'h22;
        @(negedge clk);
        chk("ptr_reset_grant", {28'd0, grant_out}, 32'h2);
        @(negedge clk);
        chk("ptr_reset_reg", {24'd0, reg_q_out}, 32'h11);
        chk("ptr_reset_cnt", {24'd0, wr_count_out}, 32'd1);
        req_in = '0;
        @(negedge clk);

        // Abort: requester 0 withdraws during its grant.
        req_in = 4'b0001;
        data_in[0*DW +: DW] = 8'h77;
        @(negedge clk);
        chk("abort_grant", {28'd0, grant_out}, 32'h1);
        req_in = '0;
        @(negedge clk);
        chk_idle("abort", 8'h11, 8'd1);
        req_in = 4'b0011;
        data_in[0*DW +: DW] = 8'h33;
        @(negedge clk);
        chk("after_abort_grant", {28'd0, grant_out}, 32'h1);
        @(negedge clk);
        chk("after_abort_reg", {24'd0, reg_q_out}, 32'h33);
        chk("after_abort_cnt", {24'd0, wr_count_out}, 32'd2);
        req_in = '0;
        @(negedge clk);

        // Random phase from a fresh reset.
        reset_in = 1'b1;
        @(negedge clk);
        reset_in = 1'b0;
        mon_en   = 1'b1;
        free_at  = 0;
        ptr      = 0;
        win      = 0;
        samp_at  = -1;
        mcnt     = 8'd0;
        for (int i = 0; i < N; i++) begin
            drop_at[i] = -1;
            dat[i]     = 8'($urandom);
        end

        for (int t = 0; t < NCYC; t++) begin
            bit aborted;
            aborted = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (drop_at[i] == t) begin
                    req_in[i]  = 1'b0;
                    drop_at[i] = -1;
                end
            end
            if (t == samp_at && $urandom_range(0, 9) == 0) begin
                req_in[win] = 1'b0;
                aborted     = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                if (!req_in[i] && !(aborted && i == win)
                    && $urandom_range(0, 1) == 1) begin
                    req_in[i] = 1'b1;
                end
                if ($urandom_range(0, 3) == 0) begin
                    dat[i] = 8'($urandom);
                end
                data_in[i*DW +: DW] = dat[i];
            end
            if (t == samp_at) begin
                if (aborted) begin
                    free_at      = t + 1;
                    drop_at[win] = -1;
                end else begin
                    exp_t e;
                    mcnt = mcnt + 8'd1;
                    e.w  = win;
                    e.d  = dat[win];
                    e.c  = mcnt;
                    aq.push_back(e);
                    ptr = (win + 1) % N;
                end
                samp_at = -1;
            end else if (t >= free_at && req_in != 0) begin
                for (int k = N - 1; k >= 0; k--) begin
                    if (req_in[(ptr + k) % N]) begin
                        win = (ptr + k) % N;
                    end
                end
                gq.push_back(win);
                samp_at      = t + 1;
                free_at      = t + 3;
                drop_at[win] = t + 2;
            end
            @(negedge clk);
        end

        req_in = '0;
        repeat (8) @(negedge clk);
        mon_en = 1'b0;
        chk("grant_queue_drained", gq.size(), 32'd0);
        chk("ack_queue_drained", aq.size(), 32'd0);
        chk("wrapped_count", {24'd0, wr_count_out}, {24'd0, mcnt});
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
